// File: rtl/awgn_generator_mc_if.sv
// awgn_generator_mc_if: control, sample-request and noise-stream bundle for
// awgn_generator_mc.
//
// Stream handshake: a beat transfers on a rising clk edge where noise_valid and
// noise_ready are both high. Once noise_valid is raised, noise_out holds until
// that transfer. The only exception is a reseed, which withdraws the beat.
// en is a request, not a handshake. It is taken only when the source is in RUN
// and the pipeline can advance.
// dbg_state mirrors the control FSM: 0 = RUN, 1 = LOAD, 2 = WARM.
interface awgn_generator_mc_if #(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 12,
    parameter int MAG_W  = 8
);
    logic                      en;
    logic [NUM_CH*MAG_W-1:0]   noise_mag;
    logic                      seed_load;
    logic [31:0]               seed_value;
    logic                      busy;
    logic [NUM_CH*OUT_W-1:0]   noise_out;
    logic                      noise_valid;
    logic                      noise_ready;
    logic [1:0]                dbg_state;

    modport master (
        output en, noise_mag, seed_load, seed_value, noise_ready,
        input  busy, noise_out, noise_valid, dbg_state
    );

    modport slave (
        input  en, noise_mag, seed_load, seed_value, noise_ready,
        output busy, noise_out, noise_valid, dbg_state
    );
endinterface

// File: rtl/awgn_generator_mc.sv
// awgn_generator_mc: multi-channel CLT Gaussian noise source.
// Each channel sums NUM_SRC LFSR uniforms, removes the mean, scales by a
// per-channel magnitude and saturates. The result goes out as a two-stage
// valid/ready stream.
// Optional build macro: AWGN_MC_STATS_EN adds a 32-bit sample_count output that
// counts accepted beats.
module awgn_generator_mc #(
    parameter int          NUM_CH  = 2,
    parameter int          NUM_SRC = 16,
    parameter int          UNI_W   = 12,
    parameter int          OUT_W   = 12,
    parameter int          MAG_W   = 8,
    parameter int          WARMUP  = 32,
    parameter logic [31:0] SEED    = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst_n,
    awgn_generator_mc_if.slave  bus
`ifdef AWGN_MC_STATS_EN
    ,
    output logic [31:0]         sample_count
`endif
);

    localparam int LG_SRC = $clog2(NUM_SRC);
    localparam int SUM_W  = UNI_W + LG_SRC + 1;
    localparam int PROD_W = SUM_W + MAG_W + 1;
    localparam int SH     = LG_SRC + MAG_W + UNI_W - OUT_W;
    localparam logic [SUM_W-1:0]         OFFSET = SUM_W'(1) << (LG_SRC + UNI_W - 1);
    localparam logic signed [PROD_W-1:0] OMAX   = PROD_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] OMIN   = ~OMAX;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_WARM = 2'd2
    } state_t;

    // Decorrelated per-source seed; an all-zero LFSR would lock up, so use 1.
    function automatic logic [31:0] seed_of(input logic [31:0] base, input int c, input int s);
        logic [31:0] v;
        v = base ^ (32'(s) * 32'h9E3779B9) ^ (32'(c) * 32'h85EBCA6B);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    // Fibonacci step for x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] st);
        return {st[30:0], st[31] ^ st[21] ^ st[1] ^ st[0]};
    endfunction

    state_t                    state_q;
    logic [9:0]                warm_cnt_q;
    logic                      busy_q;
    logic [31:0]               lfsr_q [NUM_CH][NUM_SRC];
    logic [31:0]               lfsr_d [NUM_CH][NUM_SRC];
    logic signed [SUM_W-1:0]   sum_q [NUM_CH];
    logic signed [SUM_W-1:0]   sum_d [NUM_CH];
    logic signed [SUM_W-1:0]   sum_calc [NUM_CH];
    logic [SUM_W-1:0]          tot;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  scaled;
    logic                      v1_q, v1_d;
    logic                      noise_valid_q, noise_valid_d;
    logic [NUM_CH*OUT_W-1:0]   noise_out_q, noise_out_d, out_calc;
    logic [31:0]               seed_base_q, seed_base_d;
    logic                      adv, acc;

    // The pipeline advances unless a beat is stalled; a request is taken only in RUN.
    always_comb begin
        adv = !noise_valid_q || bus.noise_ready;
        acc = bus.en && (state_q == ST_RUN) && adv && !bus.seed_load;
    end

    // Control FSM: reseed pulse -> LOAD -> WARM (WARMUP steps) -> RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= (WARMUP == 0) ? ST_RUN : ST_WARM;
            warm_cnt_q <= 10'(WARMUP);
            busy_q     <= (WARMUP != 0);
        end else if (bus.seed_load) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    warm_cnt_q <= 10'(WARMUP);
                    if (WARMUP == 0) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_WARM;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WARM: begin
                    if (warm_cnt_q <= 10'd1) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        warm_cnt_q <= warm_cnt_q - 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage-1 value: sum of uniforms minus the mean. The modular subtract is exact because the range fits SUM_W.
    always_comb begin
        tot = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tot = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                tot = tot + SUM_W'(lfsr_q[c][s][31 -: UNI_W]);
            end
            sum_calc[c] = $signed(tot - OFFSET);
        end
    end

    // Stage-2 value: scale by magnitude, floor-shift, saturate to OUT_W.
    always_comb begin
        out_calc = '0;
        prod     = '0;
        scaled   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            prod   = PROD_W'(sum_q[c]) * PROD_W'($signed({1'b0, bus.noise_mag[c*MAG_W +: MAG_W]}));
            scaled = prod >>> SH;
            if (scaled > OMAX) begin
                out_calc[c*OUT_W +: OUT_W] = OMAX[OUT_W-1:0];
            end else if (scaled < OMIN) begin
                out_calc[c*OUT_W +: OUT_W] = OMIN[OUT_W-1:0];
            end else begin
                out_calc[c*OUT_W +: OUT_W] = scaled[OUT_W-1:0];
            end
        end
    end

    // Next-state for LFSRs and pipeline. A reseed discards in-flight samples.
    always_comb begin
        lfsr_d        = lfsr_q;
        sum_d         = sum_q;
        v1_d          = v1_q;
        noise_valid_d = noise_valid_q;
        noise_out_d   = noise_out_q;
        seed_base_d   = seed_base_q;
        if (bus.seed_load) begin
            seed_base_d = bus.seed_value;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (state_q == ST_LOAD) begin
                    lfsr_d[c][s] = seed_of(seed_base_q, c, s);
                end else if (state_q == ST_WARM || acc) begin
                    lfsr_d[c][s] = lfsr_step(lfsr_q[c][s]);
                end
            end
        end
        if (bus.seed_load || state_q == ST_LOAD) begin
            v1_d          = 1'b0;
            noise_valid_d = 1'b0;
        end else if (adv) begin
            v1_d          = acc;
            noise_valid_d = v1_q;
        end
        if (adv) begin
            sum_d       = sum_calc;
            noise_out_d = out_calc;
        end
    end

    // Datapath registers; reset seeds the LFSRs from SEED.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    lfsr_q[c][s] <= seed_of(SEED, c, s);
                end
                sum_q[c] <= '0;
            end
            v1_q          <= 1'b0;
            noise_valid_q <= 1'b0;
            noise_out_q   <= '0;
            seed_base_q   <= SEED;
        end else begin
            lfsr_q        <= lfsr_d;
            sum_q         <= sum_d;
            v1_q          <= v1_d;
            noise_valid_q <= noise_valid_d;
            noise_out_q   <= noise_out_d;
            seed_base_q   <= seed_base_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.noise_out   = noise_out_q;
    assign bus.noise_valid = noise_valid_q;
    assign bus.dbg_state   = state_q;

`ifdef AWGN_MC_STATS_EN
    logic [31:0] sample_count_q, sample_count_d;

    // Beat counter: cleared by LOAD, wraps at 2^32.
    always_comb begin
        sample_count_d = sample_count_q;
        if (state_q == ST_LOAD) begin
            sample_count_d = '0;
        end else if (noise_valid_q && bus.noise_ready) begin
            sample_count_d = sample_count_q + 32'd1;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_count_q <= '0;
        end else begin
            sample_count_q <= sample_count_d;
        end
    end

    assign sample_count = sample_count_q;
`endif

endmodule

// File: tb/tb_awgn_generator_mc.sv
// tb_awgn_generator_mc: directed stimulus with a cycle-level reference model.
// The model pushes each expected beat into exp_q when a request is taken.
// A monitor pops and compares that entry when the DUT hands the beat over.
module tb_awgn_generator_mc;

    localparam int NUM_CH  = 2;
    localparam int NUM_SRC = 16;
    localparam int OUT_W   = 12;
    localparam int MAG_W   = 8;
    localparam int WARMUP  = 32;
    localparam logic [31:0] SEED_RST = 32'hDEADBEEF;
    localparam int W = NUM_CH * OUT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    awgn_generator_mc_if #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .MAG_W(MAG_W)) bus ();

`ifdef AWGN_MC_STATS_EN
    logic [31:0] sample_count;
`endif

    awgn_generator_mc #(
        .NUM_CH(NUM_CH), .NUM_SRC(NUM_SRC), .UNI_W(12), .OUT_W(OUT_W),
        .MAG_W(MAG_W), .WARMUP(WARMUP), .SEED(SEED_RST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef AWGN_MC_STATS_EN
        ,
        .sample_count(sample_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // States encoded as on dbg_state: 0 RUN, 1 LOAD, 2 WARM.
    logic [31:0] m_lfsr [NUM_CH][NUM_SRC];
    logic [1:0]  m_state;
    int          m_cnt;
    logic        m_v1, m_valid;
    logic [31:0] m_base;
    int          m_hs;

    function automatic logic [31:0] m_seed_val(input logic [31:0] base, input int c, input int s);
        logic [31:0] a, b, v;
        a = 32'(longint'(s) * 64'h9E3779B9);
        b = 32'(longint'(c) * 64'h85EBCA6B);
        v = base ^ a ^ b;
        if (v == 0) v = 32'h1;
        return v;
    endfunction

    function automatic logic [W-1:0] m_sample(input logic [NUM_CH*MAG_W-1:0] mag);
        logic [W-1:0] r;
        longint acc, p, q;
        logic [7:0] mg;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc = 0;
            for (int s = 0; s < NUM_SRC; s++) acc += longint'(m_lfsr[c][s][31:20]);
            acc -= 16 * 2048;
            mg = mag[c*MAG_W +: MAG_W];
            p = acc * longint'(mg);
            if (p >= 0) q = p / 4096;
            else        q = -((-p + 4095) / 4096);
            if (q > 2047)  q = 2047;
            if (q < -2048) q = -2048;
            r[c*OUT_W +: OUT_W] = q[11:0];
        end
        return r;
    endfunction

    task automatic m_step_all();
        logic [31:0] st;
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < NUM_SRC; s++) begin
                st = m_lfsr[c][s];
                m_lfsr[c][s] = (st << 1) | 32'(st[31] ^ st[21] ^ st[1] ^ st[0]);
            end
    endtask

    task automatic m_load(input logic [31:0] base);
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < NUM_SRC; s++) m_lfsr[c][s] = m_seed_val(base, c, s);
    endtask

    always @(posedge clk) begin : model
        logic m_adv, m_acc;
        if (!rst_n) begin
            m_load(SEED_RST);
            m_state = 2'd2;
            m_cnt   = WARMUP;
            m_v1    = 1'b0;
            m_valid = 1'b0;
            m_hs    = 0;
            m_base  = SEED_RST;
            exp_q.delete();
        end else begin
            m_adv = !m_valid || bus.noise_ready;
            m_acc = bus.en && (m_state == 2'd0) && m_adv && !bus.seed_load;
            if (m_state == 2'd1) m_hs = 0;
            else if (m_valid && bus.noise_ready) m_hs++;
            if (m_acc) begin
                exp_q.push_back(m_sample(bus.noise_mag));
                m_step_all();
            end
            if (bus.seed_load || m_state == 2'd1) begin
                m_v1 = 1'b0;
                m_valid = 1'b0;
                if (bus.seed_load) exp_q.delete();
            end else if (m_adv) begin
                m_valid = m_v1;
                m_v1 = m_acc;
            end
            if (bus.seed_load) begin
                m_base  = bus.seed_value;
                m_state = 2'd1;
            end else if (m_state == 2'd1) begin
                m_load(m_base);
                m_state = 2'd2;
                m_cnt   = WARMUP;
            end else if (m_state == 2'd2) begin
                m_step_all();
                if (m_cnt == 1) m_state = 2'd0;
                else m_cnt--;
            end
        end
    end

    // ---------------- monitor ----------------
    logic         prev_stall = 1'b0;
    logic [W-1:0] held;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_on) begin
            chk("valid", 32'(bus.noise_valid), 32'(m_valid));
            chk("busy", 32'(bus.busy), 32'(m_state != 2'd0));
            chk("state", 32'(bus.dbg_state), 32'(m_state));
            if (prev_stall && bus.noise_valid) chk("hold", 32'(bus.noise_out), 32'(held));
            prev_stall = bus.noise_valid && !bus.noise_ready;
            held = bus.noise_out;
            if (bus.noise_valid && bus.noise_ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 32'(bus.noise_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'(bus.noise_out), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (bus.busy && k < 200) begin
            cyc(1);
            k++;
        end
    endtask

    task automatic reseed(input logic [31:0] v);
        bus.seed_load  = 1'b1;
        bus.seed_value = v;
        cyc(1);
        bus.seed_load  = 1'b0;
    endtask

    task automatic pattern(input int n);
        for (int i = 0; i < n; i++) begin
            bus.noise_ready = (i % 3) != 0;
            bus.en          = (i % 5) != 0;
            cyc(1);
        end
        bus.noise_ready = 1'b1;
        bus.en          = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.noise_ready = 1'b1;
        bus.seed_load = 1'b0;
        bus.seed_value = '0;
        bus.noise_mag = {8'd100, 8'd200};
        cyc(1);
        mon_on = 1'b1;
        cyc(2);
        chk("rst_noise_out", 32'(bus.noise_out), 32'h0);
        chk("rst_noise_valid", 32'(bus.noise_valid), 32'h0);

        // Warm-up length and first-sample latency.
        rst_n = 1'b1;
        bus.en = 1'b1;
        wait_idle(k);
        chk("warm_len", k, 32);
        k = 0;
        while (!bus.noise_valid && k < 10) begin
            cyc(1);
            k++;
        end
        chk("first_latency", k, 2);
        cyc(40);

        // Zero magnitude gives zero samples, one beat per cycle.
        bus.en = 1'b0;
        cyc(4);
        bus.noise_mag = '0;
        bus.en = 1'b1;
        cyc(2);
        for (int i = 0; i < 20; i++) begin
            chk("zero_out", 32'(bus.noise_out), 32'h0);
            chk("zero_valid", 32'(bus.noise_valid), 32'h1);
            cyc(1);
        end

        // Full-scale and small magnitudes, then a 10-cycle stall.
        bus.en = 1'b0;
        cyc(4);
        bus.noise_mag = {8'd37, 8'd255};
        bus.en = 1'b1;
        cyc(10);
        bus.noise_ready = 1'b0;
        cyc(10);
        bus.noise_ready = 1'b1;
        cyc(20);
        pattern(60);
        cyc(5);

        // Same seed twice with the same stimulus.
        for (int rep = 0; rep < 2; rep++) begin
            reseed(32'h12345678);
            wait_idle(k);
            chk("reseed_warm_len", k, 33);
            pattern(30);
        end

        // Reseed during a live stream; seed 0 forces source 0 of channel 0 to 1.
        cyc(6);
        chk("pre_load_valid", 32'(bus.noise_valid), 32'h1);
        reseed(32'h0);
        chk("load_kills_valid", 32'(bus.noise_valid), 32'h0);
        cyc(10);
        reseed(32'h0);
        wait_idle(k);
        chk("rewarm_len", k, 33);
        cyc(40);

        bus.en = 1'b0;
        cyc(6);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
`ifdef AWGN_MC_STATS_EN
        chk("sample_count", sample_count, 32'(m_hs));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
